// File: rtl/kanade_mem_pkg.sv
// Shared types and defaults for the kanade32 data RAM.
package kanade_mem_pkg;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 30;
   localparam int BYTES          = DEF_DATA_WIDTH / 8;

   typedef enum logic {
      MEM_CLEAR,
      MEM_IDLE
   } mem_state_t;
endpackage

// File: rtl/ram_read_pipe.sv
// Read-result delay line (1 or 2 stages) carrying valid, err and data.
// Data registers only load alongside a valid bit, so the output word holds
// its last read result while no read is completing.
module ram_read_pipe #(
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic          clk,
   input  logic          flush_i,
   input  logic          vld_i,
   input  logic          err_i,
   input  logic [DW-1:0] dat_i,
   output logic          vld_o,
   output logic          err_o,
   output logic [DW-1:0] dat_o
);
   logic          s1_vld_q, s1_err_q;
   logic [DW-1:0] s1_dat_q;

   // first stage: captured on the accepting edge
   always_ff @(posedge clk) begin
      if (flush_i) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_dat_q <= '0;
      end else begin
         s1_vld_q <= vld_i;
         s1_err_q <= err_i;
         if (vld_i) s1_dat_q <= dat_i;
      end
   end

   if (LAT == 2) begin : g_lat2
      logic          s2_vld_q, s2_err_q;
      logic [DW-1:0] s2_dat_q;

      // second stage: one extra edge of delay
      always_ff @(posedge clk) begin
         if (flush_i) begin
            s2_vld_q <= 1'b0;
            s2_err_q <= 1'b0;
            s2_dat_q <= '0;
         end else begin
            s2_vld_q <= s1_vld_q;
            s2_err_q <= s1_err_q;
            if (s1_vld_q) s2_dat_q <= s1_dat_q;
         end
      end

      assign vld_o = s2_vld_q;
      assign err_o = s2_err_q;
      assign dat_o = s2_dat_q;
   end else begin : g_lat1
      assign vld_o = s1_vld_q;
      assign err_o = s1_err_q;
      assign dat_o = s1_dat_q;
   end
endmodule

// File: rtl/data_ram_be.sv
// Word-addressed data RAM with byte enables, read strobe, 1/2-cycle read
// latency, out-of-range flagging and an optional post-reset zeroing sweep.
module data_ram_be
   import kanade_mem_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DEPTH          = 1024,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address,
   input  logic                    wren,
   input  logic                    rden,
   input  logic [DATA_WIDTH/8-1:0] byteena,
   input  logic [DATA_WIDTH-1:0]   data,
   output logic [DATA_WIDTH-1:0]   q,
   output logic                    q_valid,
   output logic                    ready,
   output logic                    err
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_state_t          state_q;
   logic [IW-1:0]       clr_ptr_q;
   logic                ready_q;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [IW-1:0]         idx;
   logic                  in_range, acc, wr_en, clr_we;
   logic [DATA_WIDTH-1:0] rd_word_d;

   assign idx      = address[IW-1:0];
   assign in_range = ({1'b0, address} < (ADDR_WIDTH+1)'(DEPTH));
   // requests are only looked at once the sweep is done and reset is low
   assign acc      = ready_q & (wren | rden) & ~reset;
   assign wr_en    = acc & wren & in_range;
   assign clr_we   = ~reset & (state_q == MEM_CLEAR);
   // sampled before the edge, so a same-cycle write is not visible here
   assign rd_word_d = in_range ? mem[idx] : '0;
   assign ready    = ready_q;

   // clear sweep FSM; ready comes up together with the move to idle
   always_ff @(posedge clk) begin
      if (reset) begin
         clr_ptr_q <= '0;
         if (CLEAR_ON_RESET != 0) begin
            state_q <= MEM_CLEAR;
            ready_q <= 1'b0;
         end else begin
            state_q <= MEM_IDLE;
            ready_q <= 1'b1;
         end
      end else begin
         case (state_q)
            MEM_CLEAR: begin
               if (clr_ptr_q == IW'(DEPTH - 1)) begin
                  state_q <= MEM_IDLE;
                  ready_q <= 1'b1;
               end else begin
                  clr_ptr_q <= clr_ptr_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // storage array: sweep writes take priority over byte-lane writes
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem[clr_ptr_q] <= '0;
      end else if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (byteena[b]) mem[idx][8*b +: 8] <= data[8*b +: 8];
         end
      end
   end

   ram_read_pipe #(
      .DW  (DATA_WIDTH),
      .LAT (READ_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .flush_i (reset),
      .vld_i   (acc & rden),
      .err_i   (acc & ~in_range),
      .dat_i   (rd_word_d),
      .vld_o   (q_valid),
      .err_o   (err),
      .dat_o   (q)
   );
endmodule

// File: tb/tb_data_ram_be.sv
// Bench for data_ram_be: DEPTH=16, two-cycle read latency, clear on reset.
module tb_data_ram_be;
   localparam int DW = 32, AW = 8, DEPTH = 16, LAT = 2, NB = DW / 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] address;
   logic          wren, rden;
   logic [NB-1:0] byteena;
   logic [DW-1:0] data, q;
   logic          q_valid, ready, err;

   always #5 clk = ~clk;

   data_ram_be #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
      .READ_LATENCY(LAT), .CLEAR_ON_RESET(1)
   ) dut (
      .clk(clk), .reset(reset), .address(address), .wren(wren), .rden(rden),
      .byteena(byteena), .data(data), .q(q), .q_valid(q_valid),
      .ready(ready), .err(err)
   );

   typedef struct {
      int          due;
      bit          v;
      bit          e;
      logic [DW-1:0] q;
   } exp_t;

   typedef struct {
      bit            wr;
      bit            rd;
      logic [AW-1:0] a;
      logic [NB-1:0] be;
      logic [DW-1:0] d;
      bit            ev;
      bit            ee;
      logic [DW-1:0] eq;
   } vec_t;

   exp_t sbq[$];
   int   cyc = 0, checks = 0, errors = 0;

   always @(posedge clk) cyc++;

   task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // drive one request across the next edge; queue what it should produce
   task automatic drive(bit wr, bit rd, logic [AW-1:0] a, logic [NB-1:0] be,
                        logic [DW-1:0] d, bit ev, bit ee, logic [DW-1:0] eq);
      exp_t x;
      wren = wr; rden = rd; address = a; byteena = be; data = d;
      if (ev || ee) begin
         x.due = cyc + LAT; x.v = ev; x.e = ee; x.q = eq;
         sbq.push_back(x);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(int n);
      wren = 1'b0; rden = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      @(negedge clk);
      while (!ready && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   // output monitor: every q_valid/err pulse must match the queue head on time
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (sbq.size() > 0 && sbq[0].due < cyc) begin
            checks++; errors++;
            $display("FAIL sb_missing: no output at cycle %0d, expected by %0d", cyc, sbq[0].due);
            sbq.delete(0);
         end
         if (q_valid || err) begin
            checks++;
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: cyc=%0d got v=%0b e=%0b q=%h, expected nothing",
                        cyc, q_valid, err, q);
            end else begin
               e = sbq.pop_front();
               if (e.due != cyc || q_valid !== e.v || err !== e.e || (e.v && q !== e.q)) begin
                  errors++;
                  $display("FAIL sb_out: cyc=%0d got v=%0b e=%0b q=%h, expected cyc=%0d v=%0b e=%0b q=%h",
                           cyc, q_valid, err, q, e.due, e.v, e.e, e.q);
               end
            end
         end
      end
   end

   initial begin
      vec_t tv [17];
      int   n;

      tv[0]  = '{1'b1, 1'b0, 8'd1,   4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
      tv[1]  = '{1'b1, 1'b0, 8'd1,   4'h1, 32'h000000AA, 1'b0, 1'b0, 32'h0};
      tv[2]  = '{1'b0, 1'b1, 8'd1,   4'h0, 32'h0,        1'b1, 1'b0, 32'hDEADBEAA};
      tv[3]  = '{1'b1, 1'b0, 8'd2,   4'h6, 32'h12345678, 1'b0, 1'b0, 32'h0};
      tv[4]  = '{1'b0, 1'b1, 8'd2,   4'h0, 32'h0,        1'b1, 1'b0, 32'h00345600};
      tv[5]  = '{1'b1, 1'b0, 8'd3,   4'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0};
      tv[6]  = '{1'b0, 1'b1, 8'd3,   4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      tv[7]  = '{1'b1, 1'b0, 8'd1,   4'h8, 32'h55000000, 1'b0, 1'b0, 32'h0};
      tv[8]  = '{1'b0, 1'b1, 8'd1,   4'h0, 32'h0,        1'b1, 1'b0, 32'h55ADBEAA};
      tv[9]  = '{1'b1, 1'b0, 8'd16,  4'hF, 32'hCAFEF00D, 1'b0, 1'b1, 32'h0};
      tv[10] = '{1'b0, 1'b1, 8'd16,  4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
      tv[11] = '{1'b0, 1'b1, 8'd0,   4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
      tv[12] = '{1'b1, 1'b1, 8'd1,   4'hF, 32'h22222222, 1'b1, 1'b0, 32'h55ADBEAA};
      tv[13] = '{1'b0, 1'b1, 8'd1,   4'h0, 32'h0,        1'b1, 1'b0, 32'h22222222};
      tv[14] = '{1'b0, 1'b1, 8'd200, 4'h0, 32'h0,        1'b1, 1'b1, 32'h0};
      tv[15] = '{1'b1, 1'b0, 8'd15,  4'hC, 32'hABCD1234, 1'b0, 1'b0, 32'h0};
      tv[16] = '{1'b0, 1'b1, 8'd15,  4'h0, 32'h0,        1'b1, 1'b0, 32'hABCD0000};

      reset = 1'b1; wren = 1'b0; rden = 1'b0; address = '0; byteena = '0; data = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("reset_q",       q,              32'h0);
      check("reset_q_valid", 32'(q_valid),   32'h0);
      check("reset_err",     32'(err),       32'h0);
      check("reset_ready",   32'(ready),     32'h0);

      // hammer word 0 and a read while not ready: all must be ignored
      wren = 1'b1; rden = 1'b1; address = 8'd0; byteena = 4'hF; data = 32'hFFFFFFFF;
      wait_ready(n);
      wren = 1'b0; rden = 1'b0;
      check("clear_len", 32'(n), 32'd16);
      @(posedge clk); #1;

      // whole array reads back zero, one read per cycle
      for (int a = 0; a < DEPTH; a++)
         drive(1'b0, 1'b1, AW'(a), 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 17; i++)
         drive(tv[i].wr, tv[i].rd, tv[i].a, tv[i].be, tv[i].d, tv[i].ee ? tv[i].ev : tv[i].ev,
               tv[i].ee, tv[i].eq);

      idle(LAT + 3);
      @(negedge clk);
      check("q_hold",       q,            32'hABCD0000);
      check("q_hold_valid", 32'(q_valid), 32'h0);
      @(posedge clk); #1;

      // reset with a read in flight, then reset again partway into the sweep
      wren = 1'b0; rden = 1'b1; address = 8'd2;
      @(posedge clk); #1;
      reset = 1'b1; rden = 1'b0;
      sbq.delete();
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("midclear_ready", 32'(ready), 32'h0);
      wait_ready(n);
      check("restart_clear_len", 32'(n), 32'd16);
      @(posedge clk); #1;

      // previously written words must be zero again after the sweep
      drive(1'b0, 1'b1, 8'd2,  4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 8'd1,  4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      drive(1'b0, 1'b1, 8'd15, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0);
      idle(LAT + 3);
      check("sb_drain", 32'(sbq.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
